logic_op_unit: RTL

Parametrised, registered bitwise logic unit for the digital lab: applies one of eight gate functions (BUF, NOT, AND, OR, XOR, NAND, NOR, XNOR) to WIDTH-bit operands and delivers registered results over a valid/ready stream. A built-in sweep mode walks every operand combination for a chosen gate, producing a complete truth table on the output stream without testbench stimulus. Sits between a stimulus source (bench or switch front-end) and a display/checker sink.

---
 rtl/logic_op_if.sv | 29 ++
 rtl/logic_op_unit.sv | 138 +++++++++++++
 2 files changed

// File: rtl/logic_op_if.sv
// Request/result stream bundle for logic_op_unit. The bench or front-end
// takes the master side; the unit takes the slave side.
interface logic_op_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [2:0]       in_op;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             start;
  logic [2:0]       sweep_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [2:0]       out_op;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_op, in_a, in_b, start, sweep_op, out_ready,
    input  in_ready, out_valid, out_data, out_op, out_a, out_b, busy, done
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, start, sweep_op, out_ready,
    output in_ready, out_valid, out_data, out_op, out_a, out_b, busy, done
  );
endinterface

// File: rtl/logic_op_unit.sv
// Registered bitwise gate unit with a one-entry output slot and a
// self-driven sweep mode that emits the full truth table of one gate.
module logic_op_bit (
  input  logic [2:0] op,
  input  logic       a,
  input  logic       b,
  output logic       y
);
  always_comb begin
    case (op)
      3'd0:    y = a;
      3'd1:    y = ~a;
      3'd2:    y = a & b;
      3'd3:    y = a | b;
      3'd4:    y = a ^ b;
      3'd5:    y = ~(a & b);
      3'd6:    y = ~(a | b);
      default: y = ~(a ^ b);
    endcase
  end
endmodule

module logic_op_unit #(
  parameter int WIDTH      = 8,
  parameter int SWEEP_BITS = 2
) (
  input logic      clk,
  input logic      rst,
  logic_op_if.slave bus
);
  localparam int CW = 2 * SWEEP_BITS;

  typedef enum logic [1:0] {IDLE, SWEEP, WAIT} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [2:0]       sw_op;
  logic             free, load, sweep_load, in_rdy;
  logic [2:0]       ld_op;
  logic [WIDTH-1:0] ld_a, ld_b, ld_y, sw_a, sw_b;

  logic             o_valid, o_busy, o_done;
  logic [2:0]       o_op;
  logic [WIDTH-1:0] o_data, o_a, o_b;

  assign free = !o_valid || bus.out_ready;

  // Sweep operands: high half of cnt is a, low half is b, zero-extended.
  always_comb begin
    sw_a = '0;
    sw_b = '0;
    sw_a[SWEEP_BITS-1:0] = cnt[CW-1:SWEEP_BITS];
    sw_b[SWEEP_BITS-1:0] = cnt[SWEEP_BITS-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    in_rdy     = 1'b0;
    load       = 1'b0;
    sweep_load = 1'b0;
    case (state)
      IDLE: begin
        // start wins over a simultaneous direct request
        in_rdy = free && !bus.start;
        if (bus.start)                  state_nxt = SWEEP;
        else if (bus.in_valid && in_rdy) load     = 1'b1;
      end
      SWEEP: begin
        if (free) begin
          load       = 1'b1;
          sweep_load = 1'b1;
          if (cnt == '1) state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (o_valid && bus.out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign ld_op = sweep_load ? sw_op : bus.in_op;
  assign ld_a  = sweep_load ? sw_a  : bus.in_a;
  assign ld_b  = sweep_load ? sw_b  : bus.in_b;

  logic_op_bit u_bit [WIDTH-1:0] (
    .op (ld_op),
    .a  (ld_a),
    .b  (ld_b),
    .y  (ld_y)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      sw_op   <= '0;
      o_busy  <= 1'b0;
      o_done  <= 1'b0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_op    <= '0;
      o_a     <= '0;
      o_b     <= '0;
    end else begin
      o_busy <= (state_nxt != IDLE);
      o_done <= (state == WAIT) && o_valid && bus.out_ready;
      if (state == IDLE && bus.start) begin
        sw_op <= bus.sweep_op;
        cnt   <= '0;
      end else if (sweep_load) begin
        cnt <= cnt + CW'(1);
      end
      if (load) begin
        o_valid <= 1'b1;
        o_data  <= ld_y;
        o_op    <= ld_op;
        o_a     <= ld_a;
        o_b     <= ld_b;
      end else if (o_valid && bus.out_ready) begin
        o_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_rdy;
  assign bus.out_valid = o_valid;
  assign bus.out_data  = o_data;
  assign bus.out_op    = o_op;
  assign bus.out_a     = o_a;
  assign bus.out_b     = o_b;
  assign bus.busy      = o_busy;
  assign bus.done      = o_done;
endmodule
